// File: rtl/core_seq_ctrl_pkg.sv
// rtl/core_seq_ctrl_pkg.sv - shared state encoding, default widths and beat type for core_seq_ctrl
package core_seq_ctrl_pkg;

    // Default geometry; sized to match the core_top layer table.
    localparam int ADDR_W_DEF     = 10;
    localparam int CNT_W_DEF      = 12;
    localparam int NUM_LAYERS_DEF = 20;
    localparam int LAYER_W_DEF    = 5;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_NEXT      = 3'd4
    } seq_state_e;

    // One buffer read as seen by core_top once the data returns.
    typedef struct packed {
        logic vld;
        logic first;
        logic last;
    } seq_beat_t;

endpackage

// File: rtl/core_seq_ctrl_if.sv
// rtl/core_seq_ctrl_if.sv - host/buffer/core_top signal bundle for core_seq_ctrl
interface core_seq_ctrl_if
    import core_seq_ctrl_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int LAYER_W = LAYER_W_DEF
) ();

    logic               i_Start;
    logic [CNT_W-1:0]   i_Num_Acc;
    logic [CNT_W-1:0]   i_Num_Tile;
    logic [ADDR_W-1:0]  i_Base_Addr;
    logic               i_Stall;
    logic               i_Layer_Done;

    logic               o_Rd_En;
    logic [ADDR_W-1:0]  o_Rd_Addr;
    logic               o_Core_Vld;
    logic               o_Sel_Bias;
    logic               o_Flush;
    logic [LAYER_W-1:0] o_Layer_Num;
    logic               o_Cfg_Req;
    logic               o_Busy;
    logic               o_Done;

    // The sequencer itself.
    modport slave (
        input  i_Start, i_Num_Acc, i_Num_Tile, i_Base_Addr, i_Stall, i_Layer_Done,
        output o_Rd_En, o_Rd_Addr, o_Core_Vld, o_Sel_Bias, o_Flush,
        output o_Layer_Num, o_Cfg_Req, o_Busy, o_Done
    );

    // Host / config / buffer side driving the sequencer.
    modport master (
        output i_Start, i_Num_Acc, i_Num_Tile, i_Base_Addr, i_Stall, i_Layer_Done,
        input  o_Rd_En, o_Rd_Addr, o_Core_Vld, o_Sel_Bias, o_Flush,
        input  o_Layer_Num, o_Cfg_Req, o_Busy, o_Done
    );

endinterface

// File: rtl/core_seq_ctrl_seq_delay_line.sv
// rtl/core_seq_ctrl_seq_delay_line.sv - registered pipe aligning read flags with buffer data
module seq_delay_line
    import core_seq_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic vld_i,
    input  logic first_i,
    input  logic last_i,
    output logic vld_o,
    output logic first_o,
    output logic last_o
);

    seq_beat_t beat_q;
    seq_beat_t beat_d;

    // Pack the flags so extra stages can be added by widening this one register.
    always_comb begin
        beat_d       = '0;
        beat_d.vld   = vld_i;
        beat_d.first = first_i;
        beat_d.last  = last_i;
    end

    // One stage matches the single-cycle buffer read latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign vld_o   = beat_q.vld;
    assign first_o = beat_q.first;
    assign last_o  = beat_q.last;

endmodule

// File: rtl/core_seq_ctrl.sv
// rtl/core_seq_ctrl.sv - layer/tile read sequencer feeding core_top
module core_seq_ctrl
    import core_seq_ctrl_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int LAYER_W    = LAYER_W_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    core_seq_ctrl_if.slave bus
);

    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

    seq_state_e         state_q, state_d;
    logic [CNT_W-1:0]   num_acc_q, num_acc_d;
    logic [CNT_W-1:0]   num_tile_q, num_tile_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]   tile_cnt_q, tile_cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  last_addr_q, last_addr_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic               cfg_req_q, cfg_req_d;
    logic               done_q, done_d;

    logic               rd_en;
    logic               rd_first;
    logic               rd_last;

    // Next-state and read-issue decode; counters only move on an issued read.
    always_comb begin
        state_d     = state_q;
        num_acc_d   = num_acc_q;
        num_tile_d  = num_tile_q;
        acc_cnt_d   = acc_cnt_q;
        tile_cnt_d  = tile_cnt_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        layer_d     = layer_q;
        cfg_req_d   = 1'b0;
        done_d      = 1'b0;
        rd_en       = 1'b0;
        rd_first    = 1'b0;
        rd_last     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_Start) begin
                    layer_d   = '0;
                    cfg_req_d = 1'b1;
                    state_d   = ST_LOAD;
                end
            end

            ST_LOAD: begin
                num_acc_d  = bus.i_Num_Acc;
                num_tile_d = bus.i_Num_Tile;
                acc_cnt_d  = '0;
                tile_cnt_d = '0;
                addr_d     = bus.i_Base_Addr;
                // An empty layer produces nothing for core_top to finish, so skip the wait.
                if ((bus.i_Num_Acc == '0) || (bus.i_Num_Tile == '0)) begin
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (!bus.i_Stall) begin
                    rd_en       = 1'b1;
                    rd_first    = (acc_cnt_q == '0);
                    rd_last     = (acc_cnt_q == num_acc_q - CNT_W'(1));
                    addr_d      = addr_q + ADDR_W'(1);
                    last_addr_d = addr_q;
                    if (rd_last) begin
                        acc_cnt_d  = '0;
                        tile_cnt_d = tile_cnt_q + CNT_W'(1);
                        if (tile_cnt_q == num_tile_q - CNT_W'(1)) begin
                            state_d = ST_WAIT_DONE;
                        end
                    end else begin
                        acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_WAIT_DONE: begin
                if (bus.i_Layer_Done) begin
                    state_d = ST_NEXT;
                end
            end

            ST_NEXT: begin
                if (layer_q == LAST_LAYER) begin
                    done_d  = 1'b1;
                    layer_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    layer_d   = layer_q + LAYER_W'(1);
                    cfg_req_d = 1'b1;
                    state_d   = ST_LOAD;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts a run on the spot.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            num_acc_q   <= '0;
            num_tile_q  <= '0;
            acc_cnt_q   <= '0;
            tile_cnt_q  <= '0;
            addr_q      <= '0;
            last_addr_q <= '0;
            layer_q     <= '0;
            cfg_req_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_acc_q   <= num_acc_d;
            num_tile_q  <= num_tile_d;
            acc_cnt_q   <= acc_cnt_d;
            tile_cnt_q  <= tile_cnt_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            layer_q     <= layer_d;
            cfg_req_q   <= cfg_req_d;
            done_q      <= done_d;
        end
    end

    seq_delay_line u_delay (
        .clk_i   (CLK),
        .rst_i   (RST),
        .vld_i   (rd_en),
        .first_i (rd_first),
        .last_i  (rd_last),
        .vld_o   (bus.o_Core_Vld),
        .first_o (bus.o_Sel_Bias),
        .last_o  (bus.o_Flush)
    );

    // Read strobe follows i_Stall in the same cycle; the address parks on the last read issued.
    assign bus.o_Rd_En     = rd_en;
    assign bus.o_Rd_Addr   = rd_en ? addr_q : last_addr_q;
    assign bus.o_Layer_Num = layer_q;
    assign bus.o_Cfg_Req   = cfg_req_q;
    assign bus.o_Busy      = (state_q != ST_IDLE);
    assign bus.o_Done      = done_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb/tb_core_seq_ctrl.sv - directed self-checking bench for core_seq_ctrl
module tb_core_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stall, ldone, sel;
    logic [11:0] num_acc, num_tile;
    logic [9:0]  base;

    int n_checks = 0;
    int n_fail   = 0;

    core_seq_ctrl_if #(.ADDR_W(10), .CNT_W(12), .LAYER_W(5)) s1 ();
    core_seq_ctrl_if #(.ADDR_W(10), .CNT_W(12), .LAYER_W(5)) s4 ();

    core_seq_ctrl #(.ADDR_W(10), .CNT_W(12), .NUM_LAYERS(1), .LAYER_W(5)) dut1 (
        .CLK (clk),
        .RST (rst),
        .bus (s1)
    );

    core_seq_ctrl #(.ADDR_W(10), .CNT_W(12), .NUM_LAYERS(4), .LAYER_W(5)) dut4 (
        .CLK (clk),
        .RST (rst),
        .bus (s4)
    );

    assign s1.i_Start      = start;
    assign s1.i_Num_Acc    = num_acc;
    assign s1.i_Num_Tile   = num_tile;
    assign s1.i_Base_Addr  = base;
    assign s1.i_Stall      = stall;
    assign s1.i_Layer_Done = ldone;
    assign s4.i_Start      = start;
    assign s4.i_Num_Acc    = num_acc;
    assign s4.i_Num_Tile   = num_tile;
    assign s4.i_Base_Addr  = base;
    assign s4.i_Stall      = stall;
    assign s4.i_Layer_Done = ldone;

    logic       m_rd_en, m_vld, m_bias, m_flush, m_cfg, m_busy, m_done;
    logic [9:0] m_addr;
    logic [4:0] m_layer;

    assign m_rd_en = sel ? s4.o_Rd_En     : s1.o_Rd_En;
    assign m_addr  = sel ? s4.o_Rd_Addr   : s1.o_Rd_Addr;
    assign m_vld   = sel ? s4.o_Core_Vld  : s1.o_Core_Vld;
    assign m_bias  = sel ? s4.o_Sel_Bias  : s1.o_Sel_Bias;
    assign m_flush = sel ? s4.o_Flush     : s1.o_Flush;
    assign m_layer = sel ? s4.o_Layer_Num : s1.o_Layer_Num;
    assign m_cfg   = sel ? s4.o_Cfg_Req   : s1.o_Cfg_Req;
    assign m_busy  = sel ? s4.o_Busy      : s1.o_Busy;
    assign m_done  = sel ? s4.o_Done      : s1.o_Done;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // From IDLE: pulse start and land in the LOAD cycle of layer 0.
    task automatic start_run(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        check_eq({tag, " cfg_req"}, 32'(m_cfg), 32'd1);
        check_eq({tag, " layer"}, 32'(m_layer), 32'd0);
        check_eq({tag, " busy"}, 32'(m_busy), 32'd1);
        check_eq({tag, " rd_en in load"}, 32'(m_rd_en), 32'd0);
    endtask

    // Called from a LOAD cycle; bit c of each mask is the expectation for RUN cycle c.
    task automatic run_reads(input string tag, input int n, input logic [7:0] stall_m,
                             input logic [7:0] rd_m, input logic [7:0] vld_m,
                             input logic [7:0] bias_m, input logic [7:0] flush_m,
                             input logic [9:0] b);
        logic [9:0] ea;
        logic [9:0] held;
        ea = b;
        step();
        for (int c = 0; c < n; c++) begin
            stall = stall_m[c];
            #1;
            check_eq($sformatf("%s rd_en c%0d", tag, c), 32'(m_rd_en), 32'(rd_m[c]));
            if (rd_m[c]) begin
                check_eq($sformatf("%s addr c%0d", tag, c), 32'(m_addr), 32'(ea));
                ea = ea + 10'd1;
            end else begin
                held = ea - 10'd1;
                check_eq($sformatf("%s held addr c%0d", tag, c), 32'(m_addr), 32'(held));
            end
            check_eq($sformatf("%s vld c%0d", tag, c), 32'(m_vld), 32'(vld_m[c]));
            check_eq($sformatf("%s bias c%0d", tag, c), 32'(m_bias), 32'(bias_m[c]));
            check_eq($sformatf("%s flush c%0d", tag, c), 32'(m_flush), 32'(flush_m[c]));
            step();
        end
        stall = 1'b0;
    endtask

    // From WAIT_DONE on a single-layer instance: layer_done, NEXT, then done pulse.
    task automatic finish_single(input string tag);
        #1;
        check_eq({tag, " vld idle"}, 32'(m_vld), 32'd0);
        check_eq({tag, " busy wait"}, 32'(m_busy), 32'd1);
        check_eq({tag, " done early"}, 32'(m_done), 32'd0);
        ldone = 1'b1;
        step();
        ldone = 1'b0;
        #1;
        check_eq({tag, " busy next"}, 32'(m_busy), 32'd1);
        check_eq({tag, " done next"}, 32'(m_done), 32'd0);
        step();
        #1;
        check_eq({tag, " done pulse"}, 32'(m_done), 32'd1);
        check_eq({tag, " busy end"}, 32'(m_busy), 32'd0);
        check_eq({tag, " layer end"}, 32'(m_layer), 32'd0);
        step();
        #1;
        check_eq({tag, " done once"}, 32'(m_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no summary before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stall    = 1'b0;
        ldone    = 1'b0;
        sel      = 1'b0;
        num_acc  = '0;
        num_tile = '0;
        base     = '0;
        step();
        step();
        rst = 1'b0;
        step();
        #1;
        check_eq("rst rd_en", 32'(m_rd_en), 32'd0);
        check_eq("rst rd_addr", 32'(m_addr), 32'd0);
        check_eq("rst vld", 32'(m_vld), 32'd0);
        check_eq("rst bias", 32'(m_bias), 32'd0);
        check_eq("rst flush", 32'(m_flush), 32'd0);
        check_eq("rst layer", 32'(m_layer), 32'd0);
        check_eq("rst cfg_req", 32'(m_cfg), 32'd0);
        check_eq("rst busy", 32'(m_busy), 32'd0);
        check_eq("rst done", 32'(m_done), 32'd0);

        // Single layer, 3 acc x 2 tiles from 0x10.
        num_acc = 12'd3; num_tile = 12'd2; base = 10'h010;
        start_run("basic");
        run_reads("basic", 7, 8'h00, 8'h3F, 8'h7E, 8'h12, 8'h48, 10'h010);
        finish_single("basic");

        // Two stall cycles in the middle of a 4-acc tile.
        do_reset();
        num_acc = 12'd4; num_tile = 12'd1; base = 10'h020;
        start_run("stall");
        run_reads("stall", 7, 8'h0C, 8'h33, 8'h66, 8'h02, 8'h40, 10'h020);
        finish_single("stall");

        // Address wrap past 0x3FF.
        do_reset();
        num_acc = 12'd4; num_tile = 12'd1; base = 10'h3FE;
        start_run("wrap");
        run_reads("wrap", 5, 8'h00, 8'h0F, 8'h1E, 8'h02, 8'h10, 10'h3FE);
        finish_single("wrap");

        // One accumulation per tile: bias and flush coincide.
        do_reset();
        num_acc = 12'd1; num_tile = 12'd3; base = 10'h040;
        start_run("acc1");
        run_reads("acc1", 4, 8'h00, 8'h07, 8'h0E, 8'h0E, 8'h0E, 10'h040);
        finish_single("acc1");

        // Four layers with layer 2 empty.
        do_reset();
        sel = 1'b1;
        num_acc = 12'd1; num_tile = 12'd1; base = 10'h050;
        start_run("ml0");
        run_reads("ml0", 2, 8'h00, 8'h01, 8'h02, 8'h02, 8'h02, 10'h050);
        #1;
        check_eq("ml0 layer wait", 32'(m_layer), 32'd0);
        ldone = 1'b1;
        step();
        ldone = 1'b0;
        #1;
        check_eq("ml0 layer next", 32'(m_layer), 32'd0);
        check_eq("ml0 cfg next", 32'(m_cfg), 32'd0);
        step();
        #1;
        check_eq("ml1 layer", 32'(m_layer), 32'd1);
        check_eq("ml1 cfg_req", 32'(m_cfg), 32'd1);
        run_reads("ml1", 2, 8'h00, 8'h01, 8'h02, 8'h02, 8'h02, 10'h050);
        #1;
        check_eq("ml1 layer wait", 32'(m_layer), 32'd1);
        ldone = 1'b1;
        step();
        ldone = 1'b0;
        num_tile = 12'd0;
        #1;
        check_eq("ml1 layer next", 32'(m_layer), 32'd1);
        step();
        #1;
        check_eq("ml2 layer", 32'(m_layer), 32'd2);
        check_eq("ml2 cfg_req", 32'(m_cfg), 32'd1);
        step();
        #1;
        check_eq("ml2 no read", 32'(m_rd_en), 32'd0);
        check_eq("ml2 layer next", 32'(m_layer), 32'd2);
        check_eq("ml2 busy", 32'(m_busy), 32'd1);
        num_tile = 12'd1;
        step();
        #1;
        check_eq("ml3 layer", 32'(m_layer), 32'd3);
        check_eq("ml3 cfg_req", 32'(m_cfg), 32'd1);
        run_reads("ml3", 2, 8'h00, 8'h01, 8'h02, 8'h02, 8'h02, 10'h050);
        #1;
        check_eq("ml3 layer wait", 32'(m_layer), 32'd3);
        check_eq("ml3 done early", 32'(m_done), 32'd0);
        ldone = 1'b1;
        step();
        ldone = 1'b0;
        step();
        #1;
        check_eq("ml done pulse", 32'(m_done), 32'd1);
        check_eq("ml layer end", 32'(m_layer), 32'd0);
        check_eq("ml busy end", 32'(m_busy), 32'd0);

        // Stray start/layer_done pulses, then reset in the middle of RUN.
        do_reset();
        sel = 1'b0;
        num_acc = 12'd4; num_tile = 12'd2; base = 10'h000;
        start_run("stray");
        start = 1'b1;
        ldone = 1'b1;
        step();
        start = 1'b0;
        ldone = 1'b0;
        #1;
        check_eq("stray load rd_en", 32'(m_rd_en), 32'd1);
        check_eq("stray load addr", 32'(m_addr), 32'd0);
        check_eq("stray load cfg", 32'(m_cfg), 32'd0);
        start = 1'b1;
        ldone = 1'b1;
        step();
        start = 1'b0;
        ldone = 1'b0;
        #1;
        check_eq("stray run rd_en", 32'(m_rd_en), 32'd1);
        check_eq("stray run addr", 32'(m_addr), 32'd1);
        check_eq("stray run vld", 32'(m_vld), 32'd1);
        check_eq("stray run bias", 32'(m_bias), 32'd1);
        check_eq("stray run cfg", 32'(m_cfg), 32'd0);
        step();
        #1;
        check_eq("pre-rst addr", 32'(m_addr), 32'd2);
        check_eq("pre-rst vld", 32'(m_vld), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("abort rd_en", 32'(m_rd_en), 32'd0);
        check_eq("abort addr", 32'(m_addr), 32'd0);
        check_eq("abort vld", 32'(m_vld), 32'd0);
        check_eq("abort bias", 32'(m_bias), 32'd0);
        check_eq("abort flush", 32'(m_flush), 32'd0);
        check_eq("abort busy", 32'(m_busy), 32'd0);
        check_eq("abort layer", 32'(m_layer), 32'd0);
        check_eq("abort cfg", 32'(m_cfg), 32'd0);
        check_eq("abort done", 32'(m_done), 32'd0);
        step();
        rst = 1'b0;
        step();
        step();
        #1;
        check_eq("post-rst busy", 32'(m_busy), 32'd0);
        check_eq("post-rst vld", 32'(m_vld), 32'd0);
        check_eq("post-rst flush", 32'(m_flush), 32'd0);
        check_eq("post-rst rd_en", 32'(m_rd_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
